div_unit: RTL and testbench

- Multi-cycle integer divider for the CPU datapath. Computes one quotient bit per clock using a restoring shift-subtract algorithm.
- Sits directly upstream of the writeback-select mux2. Its quotient/remainder registers feed that mux's data inputs, and `done` qualifies the select.
- Uses a start/busy/done handshake so the control unit can stall the pipeline while the division runs.

---
 rtl/div_unit.sv | 262 ++++++++++++++++++++++++++
 tb/tb_div_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- multi-cycle restoring integer divider (one quotient bit / clock)
//
// Computes quotient and remainder of dividend / divisor in either unsigned or
// two's-complement mode. Results are truncated toward zero and the remainder
// carries the sign of the dividend. A start/busy/done handshake lets the
// control unit stall the pipeline while the division runs. Quotient and
// remainder are registered and feed the writeback-select mux directly.
//
// Optional feature (compile-time macro DIV_EARLY_OUT_EN):
//   When defined, a division by zero or one with |dividend| < |divisor|
//   skips the iteration loop and completes 2 cycles after the start edge.
//   When undefined, every division takes bitwidth+1 cycles.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   request a division (accepted in IDLE or DONE)
//   is_signed    in   1 = two's-complement, 0 = unsigned; sampled with start
//   dividend     in   [bitwidth-1:0] numerator; sampled with start
//   divisor      in   [bitwidth-1:0] denominator; sampled with start
//   busy         out  high while a division is in progress
//   done         out  one-cycle pulse when results become valid
//   quotient     out  [bitwidth-1:0] registered quotient
//   remainder    out  [bitwidth-1:0] registered remainder
//   div_by_zero  out  registered flag: last division had divisor == 0
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int bitwidth = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_signed,
    input  logic [bitwidth-1:0] dividend,
    input  logic [bitwidth-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [bitwidth-1:0] quotient,
    output logic [bitwidth-1:0] remainder,
    output logic                div_by_zero
);

    localparam int cnt_w = (bitwidth > 2) ? $clog2(bitwidth) : 1;
    localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);
    localparam logic [cnt_w-1:0] cnt_zero = cnt_w'(0);
    localparam logic [cnt_w-1:0] cnt_load = cnt_w'(bitwidth - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement negation at the operand width.
    function automatic logic [bitwidth-1:0] negate(input logic [bitwidth-1:0] v);
        return (~v) + {{(bitwidth-1){1'b0}}, 1'b1};
    endfunction

    state_t              state_r;
    state_t              next_state_s;

    logic [cnt_w-1:0]    cnt_r;
    logic                sgn_mode_r;     // division was signed
    logic                dvd_neg_r;      // dividend was negative (signed mode)
    logic                dvs_neg_r;      // divisor was negative (signed mode)
    logic                dvs_zero_r;     // divisor was zero
    logic [bitwidth-1:0] orig_dvd_r;     // original dividend, for /0 result
    logic [bitwidth-1:0] dvd_r;          // dividend magnitude, shifts into quotient
    logic [bitwidth-1:0] dvs_r;          // divisor magnitude
    logic [bitwidth-1:0] rem_r;          // partial remainder (always < divisor)

`ifdef DIV_EARLY_OUT_EN
    logic                early_r;        // skip iterations for this division
`endif

    logic                accept_s;
    logic                dvd_neg_s;
    logic                dvs_neg_s;
    logic [bitwidth-1:0] dvd_mag_s;
    logic [bitwidth-1:0] dvs_mag_s;

    logic [bitwidth:0]   rem_shift_s;
    logic [bitwidth:0]   diff_s;
    logic                borrow_s;
    logic                q_bit_s;
    logic [bitwidth-1:0] rem_next_s;
    logic                unused_diff_msb_s;

    logic [bitwidth-1:0] q_fix_s;
    logic [bitwidth-1:0] r_fix_s;

    // A start is only honoured when no division is in flight.
    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));

    // Operand magnitudes: absolute value in signed mode, raw value otherwise.
    always_comb begin
        dvd_neg_s = is_signed & dividend[bitwidth-1];
        dvs_neg_s = is_signed & divisor[bitwidth-1];
        if (dvd_neg_s) begin
            dvd_mag_s = negate(dividend);
        end else begin
            dvd_mag_s = dividend;
        end
        if (dvs_neg_s) begin
            dvs_mag_s = negate(divisor);
        end else begin
            dvs_mag_s = divisor;
        end
    end

    // One restoring iteration: shift in next dividend bit, trial-subtract.
    always_comb begin
        rem_shift_s             = {rem_r, dvd_r[bitwidth-1]};
        {borrow_s, diff_s}      = {1'b0, rem_shift_s} - {2'b00, dvs_r};
        q_bit_s                 = ~borrow_s;
        // A successful subtraction leaves a value below the divisor, so its
        // top bit is always zero and the remainder fits bitwidth bits.
        unused_diff_msb_s       = diff_s[bitwidth];
        if (borrow_s) begin
            rem_next_s = rem_shift_s[bitwidth-1:0];
        end else begin
            rem_next_s = diff_s[bitwidth-1:0];
        end
    end

    // Final result selection including sign correction and special cases.
    always_comb begin
        q_fix_s = dvd_r;
        r_fix_s = rem_r;
        if (dvs_zero_r) begin
            q_fix_s = {bitwidth{1'b1}};
            r_fix_s = orig_dvd_r;
`ifdef DIV_EARLY_OUT_EN
        end else if (early_r) begin
            q_fix_s = {bitwidth{1'b0}};
            r_fix_s = orig_dvd_r;
`endif
        end else begin
            // Most-negative / -1 naturally yields the most-negative value here.
            if (sgn_mode_r && (dvd_neg_r ^ dvs_neg_r)) begin
                q_fix_s = negate(dvd_r);
            end else begin
                q_fix_s = dvd_r;
            end
            if (sgn_mode_r && dvd_neg_r) begin
                r_fix_s = negate(rem_r);
            end else begin
                r_fix_s = rem_r;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
`ifdef DIV_EARLY_OUT_EN
                if (early_r || (cnt_r == cnt_zero)) begin
`else
                if (cnt_r == cnt_zero) begin
`endif
                    next_state_s = FIX;
                end else begin
                    next_state_s = CALC;
                end
            end
            FIX: begin
                next_state_s = DONE;
            end
            DONE: begin
                if (accept_s) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {bitwidth{1'b0}};
            remainder   <= {bitwidth{1'b0}};
            div_by_zero <= 1'b0;
            cnt_r       <= cnt_zero;
            sgn_mode_r  <= 1'b0;
            dvd_neg_r   <= 1'b0;
            dvs_neg_r   <= 1'b0;
            dvs_zero_r  <= 1'b0;
            orig_dvd_r  <= {bitwidth{1'b0}};
            dvd_r       <= {bitwidth{1'b0}};
            dvs_r       <= {bitwidth{1'b0}};
            rem_r       <= {bitwidth{1'b0}};
`ifdef DIV_EARLY_OUT_EN
            early_r     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        busy       <= 1'b1;
                        sgn_mode_r <= is_signed;
                        dvd_neg_r  <= dvd_neg_s;
                        dvs_neg_r  <= dvs_neg_s;
                        dvs_zero_r <= (divisor == {bitwidth{1'b0}});
                        orig_dvd_r <= dividend;
                        dvd_r      <= dvd_mag_s;
                        dvs_r      <= dvs_mag_s;
                        rem_r      <= {bitwidth{1'b0}};
                        cnt_r      <= cnt_load;
`ifdef DIV_EARLY_OUT_EN
                        early_r    <= (divisor == {bitwidth{1'b0}}) ||
                                      (dvd_mag_s < dvs_mag_s);
`endif
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    dvd_r <= {dvd_r[bitwidth-2:0], q_bit_s};
                    cnt_r <= cnt_r - cnt_one;
                end
                FIX: begin
                    quotient    <= q_fix_s;
                    remainder   <= r_fix_s;
                    div_by_zero <= dvs_zero_r;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- directed self-checking bench for div_unit (bitwidth = 32).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// Cycle k means the state just after the k-th rising edge, where the edge
// that samples start is cycle 0.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks;
    int failures;

`ifdef DIV_EARLY_OUT_EN
    localparam int early_lat = 2;
`else
    localparam int early_lat = 33;
`endif

    div_unit #(.bitwidth(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division, wait (bounded) for done, check latency and results.
    task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input logic edbz, input int elat);
        int n;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            tick();
            n++;
        end
        check_val({tag, "_latency"}, 32'(n), 32'(elat));
        check_val({tag, "_q"}, quotient, eq);
        check_val({tag, "_r"}, remainder, er);
        check_val({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    endtask

    initial begin
        int done_cnt;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        tick();
        tick();
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_q", quotient, 32'd0);
        check_val("rst_r", remainder, 32'd0);
        check_val("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        tick();

        // 100 / 7 unsigned, ignored start at cycle 10, back-to-back 50 / 5 at DONE.
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        start     = 1'b1;
        tick();                                   // cycle 0
        for (int c = 1; c <= 67; c++) begin
            if (c == 10 || c == 34) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end else begin
                start    = 1'b0;
            end
            tick();
            if (c <= 32 || (c >= 34 && c <= 66)) begin
                check_val($sformatf("busy_c%0d", c), {31'd0, busy}, 32'd1);
                check_val($sformatf("done_c%0d", c), {31'd0, done}, 32'd0);
            end else begin
                check_val($sformatf("busy_c%0d", c), {31'd0, busy}, 32'd0);
                check_val($sformatf("done_c%0d", c), {31'd0, done}, 32'd1);
            end
            if (c == 33 || c == 34) begin
                check_val($sformatf("u100_7_q_c%0d", c), quotient, 32'd14);
                check_val($sformatf("u100_7_r_c%0d", c), remainder, 32'd2);
                check_val($sformatf("u100_7_dbz_c%0d", c), {31'd0, div_by_zero}, 32'd0);
            end
            if (c == 67) begin
                check_val("u50_5_q", quotient, 32'd10);
                check_val("u50_5_r", remainder, 32'd0);
            end
        end
        start = 1'b0;
        tick();

        run_div("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        run_div("s_7_m2",   1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 33);
        run_div("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0, 33);
        run_div("u_big",    1'b0, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 32'd15,       1'b0, 33);
        run_div("u_5_0",    1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,        1'b1, early_lat);
        run_div("s_5_0",    1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,        1'b1, early_lat);
        run_div("u_9_3",    1'b0, 32'd9,         32'd3,         32'd3,         32'd0,        1'b0, 33);
        run_div("u_3_10",   1'b0, 32'd3,         32'd10,        32'd0,         32'd3,        1'b0, early_lat);
        run_div("s_m3_10",  1'b1, 32'hFFFF_FFFD, 32'd10,        32'd0,         32'hFFFF_FFFD, 1'b0, early_lat);
        run_div("u_10_3",   1'b0, 32'd10,        32'd3,         32'd3,         32'd1,        1'b0, 33);
        run_div("s_m5_0",   1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, early_lat);

        // Reset mid-division at cycle 15, with start held high on the same edge.
        tick();
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        start     = 1'b1;
        tick();                                   // cycle 0
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
        end
        rst   = 1'b1;
        start = 1'b1;
        tick();                                   // cycle 15
        rst   = 1'b0;
        start = 1'b0;
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst_done", {31'd0, done}, 32'd0);
        check_val("mid_rst_q", quotient, 32'd0);
        check_val("mid_rst_r", remainder, 32'd0);
        check_val("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
        done_cnt = 0;
        for (int c = 16; c <= 55; c++) begin
            tick();
            if (done || busy) begin
                done_cnt++;
            end
        end
        check_val("mid_rst_no_activity", 32'(done_cnt), 32'd0);

        run_div("post_rst_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
